// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode encodings (OP_ADD .. OP_ADC)
//   - bit positions of the {C,Z,N,V} flag register
//   - handshake FSM state encoding
//   - is_engine_op(): true for ops executed by the iterative engine
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_ASR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_ROL = 4'd9;
    localparam logic [3:0] OP_ROR = 4'd10;
    localparam logic [3:0] OP_NOT = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12;
    localparam logic [3:0] OP_ADC = 4'd13;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Shifts/rotates always go to the engine; MUL only when it is built in.
    function automatic logic is_engine_op(input logic [3:0] op, input logic mul_en);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR) ||
               (op == OP_ROL) || (op == OP_ROR) || ((op == OP_MUL) && mul_en);
    endfunction

endpackage

// File: rtl/seq_shift_mul.sv
// seq_shift_mul: iterative shift / rotate / multiply engine.
//   One shift/rotate bit per cycle, or one shift-add multiply step per cycle.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     start           load operands and op (one-cycle pulse on accept)
//     op, a, b        opcode, first operand, second operand / shift amount
//     last            high during the final busy cycle
//     result, carry   value the engine will hold after the current step;
//                     valid to capture on the edge where last is high
module seq_shift_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    logic               busy_reg;
    logic [CW-1:0]      count_reg;
    logic [3:0]         op_reg;
    logic               move_reg;
    logic               carry_reg;
    logic               carry_next;
    logic [WIDTH-1:0]   mcand_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH:0]     sum;
    logic [SW-1:0]      amt;

    assign amt = b[SW-1:0];
    assign lo  = prod_reg[WIDTH-1:0];
    assign hi  = prod_reg[2*WIDTH-1:WIDTH];

    // Shifts work in the low half only. MUL keeps {partial_high, multiplier}
    // and shifts the sum back in from the top each step.
    always_comb begin
        prod_next  = prod_reg;
        carry_next = carry_reg;
        sum        = {1'b0, hi} + {1'b0, (lo[0] ? mcand_reg : {WIDTH{1'b0}})};
        case (op_reg)
            OP_SHL: if (move_reg) begin
                prod_next[WIDTH-1:0] = {lo[WIDTH-2:0], 1'b0};
                carry_next           = lo[WIDTH-1];
            end
            OP_SHR: if (move_reg) begin
                prod_next[WIDTH-1:0] = {1'b0, lo[WIDTH-1:1]};
                carry_next           = lo[0];
            end
            OP_ASR: if (move_reg) begin
                prod_next[WIDTH-1:0] = {lo[WIDTH-1], lo[WIDTH-1:1]};
                carry_next           = lo[0];
            end
            // Rotate carry is fixed at start; the bit sweeps stay in the word.
            OP_ROL: if (move_reg) prod_next[WIDTH-1:0] = {lo[WIDTH-2:0], lo[WIDTH-1]};
            OP_ROR: if (move_reg) prod_next[WIDTH-1:0] = {lo[0], lo[WIDTH-1:1]};
            OP_MUL: prod_next = {sum, lo[WIDTH-1:1]};
            default: ;
        endcase
    end

    assign last   = busy_reg && (count_reg == CW'(1));
    assign result = prod_next[WIDTH-1:0];
    assign carry  = (op_reg == OP_MUL) ? (|prod_next[2*WIDTH-1:WIDTH]) : carry_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg  <= 1'b0;
            count_reg <= '0;
            op_reg    <= '0;
            move_reg  <= 1'b0;
            carry_reg <= 1'b0;
            mcand_reg <= '0;
            prod_reg  <= '0;
        end else if (start) begin
            busy_reg  <= 1'b1;
            op_reg    <= op;
            move_reg  <= (amt != '0);
            mcand_reg <= a;
            prod_reg  <= {{WIDTH{1'b0}}, ((op == OP_MUL) ? b : a)};
            // Amount 0 still takes one cycle, with nothing moved.
            if (op == OP_MUL)
                count_reg <= CW'(WIDTH);
            else if (amt == '0)
                count_reg <= CW'(1);
            else
                count_reg <= {1'b0, amt};
            // Rotates report the bit sitting at the boundary the word rotates across.
            if (amt == '0)
                carry_reg <= 1'b0;
            else if (op == OP_ROL)
                carry_reg <= a[WIDTH-1];
            else if (op == OP_ROR)
                carry_reg <= a[0];
            else
                carry_reg <= 1'b0;
        end else if (busy_reg) begin
            prod_reg  <= prod_next;
            carry_reg <= carry_next;
            count_reg <= count_reg - CW'(1);
            if (last)
                busy_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked sequential ALU with a persistent {C,Z,N,V} flag register.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     in_valid / in_ready   operand handshake (ready only in IDLE, rst low)
//     op, in1, in2          opcode and operands, latched on accept
//     out_valid / out_ready result handshake
//     out, flags, err       result, flag register, illegal-opcode indication
//   Single-cycle ops are computed from the latched operands during the one
//   BUSY cycle; shifts, rotates and MUL run in seq_shift_mul.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int MSB = WIDTH - 1;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [3:0]       op_reg;
    logic             cin_reg;
    logic             eng_op_reg;
    logic [WIDTH-1:0] out_reg;
    logic [3:0]       flags_reg;
    logic             err_reg;
    logic             out_valid_reg;

    logic             accept;
    logic             eng_start;
    logic             eng_last;
    logic [WIDTH-1:0] eng_result;
    logic             eng_carry;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] res_c;
    logic [WIDTH-1:0] zn_src;
    logic             c_c;
    logic             v_c;
    logic             illegal_c;
    logic [3:0]       flags_c;

    assign in_ready  = (state_reg == ST_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign eng_start = accept && is_engine_op(op, MUL_EN != 0);

    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign flags     = flags_reg;
    assign err       = err_reg;

    seq_shift_mul #(
        .WIDTH (WIDTH)
    ) u_engine (
        .clk    (clk),
        .rst    (rst),
        .start  (eng_start),
        .op     (op),
        .a      (in1),
        .b      (in2),
        .last   (eng_last),
        .result (eng_result),
        .carry  (eng_carry)
    );

    always_comb begin
        sum_w     = {1'b0, a_reg} + {1'b0, b_reg} +
                    {{WIDTH{1'b0}}, ((op_reg == OP_ADC) && cin_reg)};
        diff_w    = {1'b0, a_reg} - {1'b0, b_reg};
        res_c     = '0;
        c_c       = 1'b0;
        v_c       = 1'b0;
        illegal_c = 1'b0;
        case (op_reg)
            OP_ADD, OP_ADC: begin
                res_c = sum_w[WIDTH-1:0];
                c_c   = sum_w[WIDTH];
                v_c   = (a_reg[MSB] == b_reg[MSB]) && (sum_w[MSB] != a_reg[MSB]);
            end
            OP_SUB, OP_CMP: begin
                res_c = (op_reg == OP_CMP) ? a_reg : diff_w[WIDTH-1:0];
                c_c   = diff_w[WIDTH];   // borrow
                v_c   = (a_reg[MSB] != b_reg[MSB]) && (diff_w[MSB] != a_reg[MSB]);
            end
            OP_AND: res_c = a_reg & b_reg;
            OP_OR:  res_c = a_reg | b_reg;
            OP_XOR: res_c = a_reg ^ b_reg;
            OP_NOT: res_c = ~a_reg;
            OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR: begin
                res_c = eng_result;
                c_c   = eng_carry;
            end
            OP_MUL: begin
                if (MUL_EN != 0) begin
                    res_c = eng_result;
                    c_c   = eng_carry;
                end else begin
                    illegal_c = 1'b1;
                end
            end
            default: illegal_c = 1'b1;
        endcase
        // CMP reports Z/N of the difference while passing in1 through.
        zn_src          = (op_reg == OP_CMP) ? diff_w[WIDTH-1:0] : res_c;
        flags_c         = '0;
        flags_c[FLAG_C] = c_c;
        flags_c[FLAG_Z] = (zn_src == '0);
        flags_c[FLAG_N] = zn_src[MSB];
        flags_c[FLAG_V] = v_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            cin_reg       <= 1'b0;
            eng_op_reg    <= 1'b0;
            out_reg       <= '0;
            flags_reg     <= '0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg      <= in1;
                        b_reg      <= in2;
                        op_reg     <= op;
                        cin_reg    <= flags_reg[FLAG_C];
                        eng_op_reg <= is_engine_op(op, MUL_EN != 0);
                        err_reg    <= 1'b0;
                        state_reg  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!eng_op_reg || eng_last) begin
                        out_reg       <= res_c;
                        err_reg       <= illegal_c;
                        if (!illegal_c)
                            flags_reg <= flags_c;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [3:0] flags;
    logic       err;

    int tests;
    int failures;

    seq_alu #(
        .WIDTH  (8),
        .MUL_EN (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction: present, accept, count latency, check result, optionally
    // hold off the consumer for 'hold' cycles, then drain.
    task automatic run_op(input string name, input logic [3:0] o, input logic [7:0] a,
                          input logic [7:0] b, input int exp_lat, input logic [7:0] exp_out,
                          input logic [3:0] exp_flags, input logic exp_err, input int hold);
        int   lat;
        logic seen;
        logic rdy_bad;
        logic hold_bad;
        @(negedge clk);
        check({name, " in_ready idle"}, 32'(in_ready), 32'd1);
        op       = o;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the ALU must use the latched copies.
        in_valid = 1'b0;
        in1      = ~a;
        in2      = ~b;
        op       = 4'hF;
        lat      = 0;
        seen     = 1'b0;
        rdy_bad  = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (in_ready) rdy_bad = 1'b1;
            if (out_valid) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " in_ready busy"}, 32'(rdy_bad), 32'd0);
        check({name, " out"}, 32'(out), 32'(exp_out));
        check({name, " flags"}, 32'(flags), 32'(exp_flags));
        check({name, " err"}, 32'(err), 32'(exp_err));
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || out !== exp_out || flags !== exp_flags || err !== exp_err)
                hold_bad = 1'b1;
        end
        if (hold > 0)
            check({name, " hold stable"}, 32'(hold_bad), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " drained"}, 32'(out_valid), 32'd0);
        check({name, " ready after drain"}, 32'(in_ready), 32'd1);
        $display("[TB] %s op=%0d in1=0x%02h in2=0x%02h -> out=0x%02h flags=%04b err=%0d lat=%0d",
                 name, o, a, b, out, flags, err, lat);
    endtask

    initial begin
        logic ov_seen;
        tests     = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'd0;
        in1       = 8'd0;
        in2       = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out", 32'(out), 32'd0);
        check("reset flags", 32'(flags), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //      name     op     in1    in2    lat out    flags    err hold
        run_op("ADD",  4'd0,  8'hFF, 8'h01, 1, 8'h00, 4'b1100, 0, 0);
        run_op("ADC",  4'd13, 8'h01, 8'h01, 1, 8'h03, 4'b0000, 0, 0);
        run_op("SUB",  4'd1,  8'h80, 8'h01, 1, 8'h7F, 4'b0001, 0, 0);
        run_op("CMP",  4'd12, 8'h05, 8'h07, 1, 8'h05, 4'b1010, 0, 0);
        run_op("MUL",  4'd8,  8'h10, 8'h11, 8, 8'h10, 4'b1000, 0, 0);
        run_op("SHL",  4'd5,  8'h81, 8'h01, 1, 8'h02, 4'b1000, 0, 0);
        run_op("ROR",  4'd10, 8'h01, 8'h03, 3, 8'h20, 4'b1000, 0, 0);
        run_op("SHL0", 4'd5,  8'h81, 8'h00, 1, 8'h81, 4'b0010, 0, 0);
        run_op("SHR",  4'd6,  8'h0F, 8'h04, 4, 8'h00, 4'b1100, 0, 0);
        run_op("ASR",  4'd7,  8'h80, 8'h02, 2, 8'hE0, 4'b0010, 0, 0);
        run_op("ROL",  4'd9,  8'h80, 8'h01, 1, 8'h01, 4'b1000, 0, 0);
        run_op("AND",  4'd2,  8'hF0, 8'h3C, 1, 8'h30, 4'b0000, 0, 0);
        run_op("XOR",  4'd4,  8'hAA, 8'hAA, 1, 8'h00, 4'b0100, 0, 3);
        run_op("NOT",  4'd11, 8'h0F, 8'h00, 1, 8'hF0, 4'b0010, 0, 0);
        run_op("ILL14",4'd14, 8'h12, 8'h34, 1, 8'h00, 4'b0010, 1, 0);
        run_op("OR",   4'd3,  8'h00, 8'h00, 1, 8'h00, 4'b0100, 0, 0);

        // Reset in the middle of a multiply: accept, 3 busy edges, reset on the 4th.
        @(negedge clk);
        op       = 4'd8;
        in1      = 8'h10;
        in2      = 8'h11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mulrst out_valid", 32'(out_valid), 32'd0);
        check("mulrst flags", 32'(flags), 32'd0);
        check("mulrst in_ready in rst", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mulrst in_ready after", 32'(in_ready), 32'd1);
        ov_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) ov_seen = 1'b1;
        end
        check("mulrst no out_valid", 32'(ov_seen), 32'd0);
        $display("[TB] reset during MUL -> out_valid=%0d flags=%04b in_ready=%0d",
                 out_valid, flags, in_ready);

        run_op("ADDV", 4'd0,  8'h7F, 8'h01, 1, 8'h80, 4'b0011, 0, 0);
        run_op("ADC0", 4'd13, 8'h01, 8'h01, 1, 8'h02, 4'b0000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
